sw_ctrl_mc: RTL

//   Multi-channel software-access controller for one register field.
//   - Arbitrates SW_CNT software ports (e.g. APB and a debug port) onto one field.
//   - Applies read side-effects and masked write side-effects.
//   - Enforces the write-once attribute.
//   - Generates multi-cycle auto-clearing pulses.
//   - Emits the next field value plus swmod/swacc event strobes.
//   - Sits between the register-slice decoder and the field storage flop, beside hw_ctrl.

---
 rtl/field_attr_pkg.sv | 46 ++++
 rtl/sw_port_arb.sv | 36 +++
 rtl/sw_ctrl_mc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/field_attr_pkg.sv
// rtl/field_attr_pkg.sv - field access attribute types and write side-effect helper
package field_attr_pkg;

    typedef enum logic [2:0] {
        SW_RO  = 3'd0,
        SW_RW  = 3'd1,
        SW_RW1 = 3'd2,
        SW_WO  = 3'd3,
        SW_W1  = 3'd4
    } sw_type_e;

    typedef enum logic [1:0] {
        RD_NA = 2'd0,
        RCLR  = 2'd1,
        RSET  = 2'd2
    } onread_e;

    typedef enum logic [2:0] {
        WR_NA = 3'd0,
        WOCLR = 3'd1,
        WOSET = 3'd2,
        WOT   = 3'd3,
        WZS   = 3'd4,
        WZC   = 3'd5,
        WZT   = 3'd6
    } onwrite_e;

    // Widest field the helper handles; callers truncate the result to their width.
    localparam int FW_MAX = 64;

    // Unmasked value a write would produce for every bit of the field.
    function automatic logic [FW_MAX-1:0] onwrite_fn(input onwrite_e t,
                                                     input logic [FW_MAX-1:0] field,
                                                     input logic [FW_MAX-1:0] data);
        case (t)
            WOCLR:   return field & ~data;
            WOSET:   return field | data;
            WOT:     return field ^ data;
            WZS:     return field | ~data;
            WZC:     return field & data;
            WZT:     return field ^ ~data;
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/sw_port_arb.sv
// rtl/sw_port_arb.sv - fixed-priority one-hot port arbiter with data/mask mux
module sw_port_arb #(
    parameter int F_WIDTH = 8,
    parameter int SW_CNT  = 2
) (
    input  logic [SW_CNT-1:0]         i_rd,
    input  logic [SW_CNT-1:0]         i_wr,
    input  logic [SW_CNT*F_WIDTH-1:0] i_data,
    input  logic [SW_CNT*F_WIDTH-1:0] i_mask,
    output logic [SW_CNT-1:0]         o_grant,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic [F_WIDTH-1:0]        o_data,
    output logic [F_WIDTH-1:0]        o_mask
);

    // Scan from the highest index down so the lowest requesting port overrides last.
    always_comb begin
        o_grant = '0;
        o_rd    = 1'b0;
        o_wr    = 1'b0;
        o_data  = '0;
        o_mask  = '0;
        for (int i = SW_CNT - 1; i >= 0; i--) begin
            if (i_rd[i] | i_wr[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_rd       = i_rd[i];
                o_wr       = i_wr[i];
                o_data     = i_data[i*F_WIDTH +: F_WIDTH];
                o_mask     = i_mask[i*F_WIDTH +: F_WIDTH];
            end
        end
    end

endmodule

// File: rtl/sw_ctrl_mc.sv
// rtl/sw_ctrl_mc.sv - multi-port software access controller for one register field
module sw_ctrl_mc
    import field_attr_pkg::*;
#(
    parameter int       F_WIDTH         = 8,
    parameter int       SW_CNT          = 2,
    parameter sw_type_e SW_TYPE         = SW_RW,
    parameter onread_e  SW_ONREAD_TYPE  = RD_NA,
    parameter onwrite_e SW_ONWRITE_TYPE = WR_NA,
    parameter bit       SWMOD           = 1'b0,
    parameter bit       SWACC           = 1'b0,
    parameter int       PULSE_CYCLES    = 0
) (
    input  logic                      clk,
    input  logic                      sync_rst,
    input  logic [SW_CNT-1:0]         sw_rd,
    input  logic [SW_CNT-1:0]         sw_wr,
    input  logic [SW_CNT*F_WIDTH-1:0] sw_wr_data,
    input  logic [SW_CNT*F_WIDTH-1:0] sw_wr_mask,
    input  logic [F_WIDTH-1:0]        field_value,
    output logic [SW_CNT-1:0]         sw_ack,
    output logic                      sw_modify,
    output logic [F_WIDTH-1:0]        nxt_sw_value,
    output logic                      swmod_out,
    output logic [SW_CNT-1:0]         swacc_rd_out,
    output logic [SW_CNT-1:0]         swacc_wr_out,
    output logic                      wr_protect_out,
    output logic                      pulse_busy
);

    localparam bit READABLE = (SW_TYPE == SW_RO) || (SW_TYPE == SW_RW) || (SW_TYPE == SW_RW1);
    localparam bit WRITABLE = (SW_TYPE != SW_RO);
    localparam bit WONCE    = (SW_TYPE == SW_RW1) || (SW_TYPE == SW_W1);
    localparam bit PULSE_EN = (PULSE_CYCLES > 0);
    localparam int CW       = PULSE_EN ? $clog2(PULSE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES);

    if (SW_TYPE > SW_W1 || SW_ONREAD_TYPE > RSET || SW_ONWRITE_TYPE > WZT) begin : g_bad_type
        $fatal(1, "sw_ctrl_mc: unknown access type");
    end
    if (PULSE_CYCLES < 0 || (PULSE_EN && SW_ONWRITE_TYPE != WR_NA)) begin : g_bad_pulse
        $fatal(1, "sw_ctrl_mc: pulse fields require onwrite NA and PULSE_CYCLES >= 0");
    end

    logic [SW_CNT-1:0]  w_grant;
    logic               w_g_rd;
    logic               w_g_wr;
    logic [F_WIDTH-1:0] w_g_data;
    logic [F_WIDTH-1:0] w_g_mask;

    logic               r_protect;
    logic [CW-1:0]      r_cnt;
    logic [F_WIDTH-1:0] r_pulse_bits;

    sw_port_arb #(
        .F_WIDTH (F_WIDTH),
        .SW_CNT  (SW_CNT)
    ) u_arb (
        .i_rd    (sw_rd),
        .i_wr    (sw_wr),
        .i_data  (sw_wr_data),
        .i_mask  (sw_wr_mask),
        .o_grant (w_grant),
        .o_rd    (w_g_rd),
        .o_wr    (w_g_wr),
        .o_data  (w_g_data),
        .o_mask  (w_g_mask)
    );

    // A read side-effect pre-empts any write carried by the same granted request.
    logic               w_do_rd;
    logic               w_rd_fx;
    logic               w_do_wr;
    logic               w_wr_ok;
    logic               w_wr_hit;
    logic               w_expire;
    logic               w_pulse_load;
    logic [F_WIDTH-1:0] w_pulse_set;
    logic [F_WIDTH-1:0] w_wr_val;
    logic [F_WIDTH-1:0] w_rd_val;
    logic [F_WIDTH-1:0] w_base;
    logic [F_WIDTH-1:0] w_clr;
    logic [F_WIDTH-1:0] w_nxt;
    logic               w_modify;
    logic               w_swmod;

    assign w_do_rd      = w_g_rd & READABLE;
    assign w_rd_fx      = w_do_rd & (SW_ONREAD_TYPE != RD_NA);
    assign w_do_wr      = w_g_wr & WRITABLE & ~w_rd_fx;
    assign w_wr_ok      = w_do_wr & ~(WONCE & r_protect);
    assign w_wr_hit     = w_wr_ok & (|w_g_mask);
    assign w_pulse_set  = w_g_data & w_g_mask;
    assign w_pulse_load = PULSE_EN & w_wr_ok & (|w_pulse_set);
    assign w_expire     = PULSE_EN & (r_cnt == CW'(1));
    assign w_rd_val     = (SW_ONREAD_TYPE == RSET) ? '1 : '0;

    // Masked write result, then the expiring pulse bits not covered by this write are dropped.
    always_comb begin
        w_wr_val = (F_WIDTH'(onwrite_fn(SW_ONWRITE_TYPE, FW_MAX'(field_value), FW_MAX'(w_g_data)))
                    & w_g_mask) | (field_value & ~w_g_mask);
        w_base   = field_value;
        if (w_rd_fx) begin
            w_base = w_rd_val;
        end else if (w_wr_hit) begin
            w_base = w_wr_val;
        end
        w_clr = '0;
        if (w_expire) begin
            w_clr = r_pulse_bits & ~(w_wr_ok ? w_g_mask : '0);
        end
        w_nxt    = w_base & ~w_clr;
        w_modify = w_rd_fx | w_wr_hit | w_expire;
        w_swmod  = w_modify & (w_nxt != field_value);
    end

    // Outputs are forced low for the whole reset cycle.
    always_comb begin
        sw_ack         = '0;
        sw_modify      = 1'b0;
        nxt_sw_value   = '0;
        swmod_out      = 1'b0;
        swacc_rd_out   = '0;
        swacc_wr_out   = '0;
        wr_protect_out = 1'b0;
        pulse_busy     = 1'b0;
        if (!sync_rst) begin
            sw_ack         = w_grant;
            sw_modify      = w_modify;
            nxt_sw_value   = w_nxt;
            swmod_out      = SWMOD & w_swmod;
            swacc_rd_out   = SWACC ? (w_grant & {SW_CNT{w_do_rd}}) : '0;
            swacc_wr_out   = SWACC ? (w_grant & {SW_CNT{w_do_wr}}) : '0;
            wr_protect_out = WONCE & r_protect;
            pulse_busy     = (r_cnt != '0);
        end
    end

    // Write-once lock: arms after the first effective write, held until reset.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_protect <= 1'b0;
        end else if (WONCE && w_wr_hit) begin
            r_protect <= 1'b1;
        end
    end

    // Pulse countdown: a write with new 1s restarts it, otherwise it runs down and clears.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_cnt        <= '0;
            r_pulse_bits <= '0;
        end else if (w_pulse_load) begin
            r_cnt        <= CNT_LOAD;
            r_pulse_bits <= w_pulse_set;
        end else if (w_expire) begin
            r_cnt        <= '0;
            r_pulse_bits <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule
